// File: rtl/lsu_ctrl.sv
// Load/store initiator for a byte-addressed, word-bounded data memory.
// Splits word-crossing accesses in two, builds byte-write masks, merges and extends load data.
module lsu_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_we, r_uns, r_err;
  logic [31:0]         r_wdata, r_rdata;
  logic                r_resp_valid, r_resp_err;
  logic [31:0]         r_resp_rdata;

  logic [2:0]          w_nbytes, w_room, w_n1, w_n2;
  logic                w_cross;
  logic [3:0]          w_mask1, w_mask2;
  logic [ADDR_W-3:0]   w_word_nxt;
  logic [31:0]         w_ext;

  function automatic logic [3:0] low_mask(input logic [2:0] n);
    case (n)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] byte_expand(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  always_comb begin
    case (r_size)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // Bytes left in the current word bound the first fragment; the rest spill into the next word.
  assign w_room     = 3'd4 - {1'b0, r_addr[1:0]};
  assign w_n1       = (w_nbytes < w_room) ? w_nbytes : w_room;
  assign w_n2       = w_nbytes - w_n1;
  assign w_cross    = (w_n2 != 3'd0);
  assign w_mask1    = low_mask(w_n1);
  assign w_mask2    = low_mask(w_n2);
  assign w_word_nxt = r_addr[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};

  always_comb begin
    case (r_size)
      2'b00:   w_ext = {{24{r_rdata[7]  & ~r_uns}}, r_rdata[7:0]};
      2'b01:   w_ext = {{16{r_rdata[15] & ~r_uns}}, r_rdata[15:0]};
      default: w_ext = r_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output and next-state is given a default first so no path leaves a latch.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 4'b0000;
    mem_addr    = r_addr;
    mem_din     = r_wdata;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = (req_size == 2'b11) ? S_DONE : S_ACC1;
      end
      S_ACC1: begin
        mem_en      = 1'b1;
        mem_we      = r_we ? w_mask1 : 4'b0000;
        w_state_nxt = w_cross ? S_ACC2 : S_DONE;
      end
      S_ACC2: begin
        mem_en      = 1'b1;
        mem_addr    = {w_word_nxt, 2'b00};
        mem_din     = r_wdata >> {w_n1, 3'b000};
        mem_we      = r_we ? w_mask2 : 4'b0000;
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A reset cycle must never write memory, even in the middle of a split store.
    if (rst) begin
      mem_en = 1'b0;
      mem_we = 4'b0000;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_size       <= 2'b00;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_err        <= 1'b0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= (r_state == S_DONE);
      r_resp_err   <= (r_state == S_DONE) && r_err;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr  <= req_addr[ADDR_W-1:0];
          r_size  <= req_size;
          r_we    <= req_we;
          r_uns   <= req_unsigned;
          r_wdata <= req_wdata;
          r_err   <= (req_size == 2'b11);
          r_rdata <= '0;
        end
        S_ACC1: if (!r_we) r_rdata <= mem_dout & byte_expand(w_mask1);
        S_ACC2: if (!r_we)
          r_rdata <= r_rdata | ((mem_dout & byte_expand(w_mask2)) << {w_n1, 3'b000});
        default: r_resp_rdata <= (r_we || r_err) ? 32'h0 : w_ext;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl against a byte-array memory that shifts by the low address bits.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din, mem_dout;

  lsu_ctrl #(.ADDR_W(14)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [3:0]  we;
    logic [13:0] addr;
    logic [31:0] din;
  } acc_t;

  exp_t sb[$];
  acc_t mem_log[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] mem [0:16383];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory model: word-bounded, write lanes shifted up and read data shifted down by addr[1:0].
  always_comb begin
    logic [13:0] b;
    logic [31:0] w;
    b = {mem_addr[13:2], 2'b00};
    w = {mem[b + 14'd3], mem[b + 14'd2], mem[b + 14'd1], mem[b]};
    mem_dout = w >> {mem_addr[1:0], 3'b000};
  end

  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_we[i] && (int'(mem_addr[1:0]) + i < 4))
          mem[{mem_addr[13:2], 2'b00} + 14'(int'(mem_addr[1:0]) + i)] = mem_din[8*i +: 8];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_en) mem_log.push_back('{mem_we, mem_addr, mem_din});
    if (rst) check("rst_mem_we", {28'h0, mem_we}, 32'h0);
  end

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rd);
        check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic set_word(input logic [13:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) mem[a + 14'(i)] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] get_word(input logic [13:0] a);
    return {mem[a + 14'd3], mem[a + 14'd2], mem[a + 14'd1], mem[a]};
  endfunction

  task automatic check_acc(input int idx, input logic [3:0] we, input logic [13:0] addr,
                           input logic [31:0] din);
    if (idx < mem_log.size()) begin
      check($sformatf("acc%0d_we", idx), {28'h0, mem_log[idx].we}, {28'h0, we});
      check($sformatf("acc%0d_addr", idx), {18'h0, mem_log[idx].addr}, {18'h0, addr});
      check($sformatf("acc%0d_din", idx), mem_log[idx].din, din);
    end else begin
      check($sformatf("acc%0d_present", idx), 32'(mem_log.size()), 32'(idx + 1));
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    int t;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("ready_timeout", 32'h0, 32'h1);
    mem_log.delete();
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int t;
    drive_req(we, size, uns, addr, wdata);
    sb.push_back('{exp_rd, exp_err, exp_lat, cyc});
    t = 0;
    while (sb.size() != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("resp_timeout", 32'h0, 32'h1);
      sb.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_mem_en", {31'h0, mem_en}, 32'h0);
    check("rst_mem_addr", {18'h0, mem_addr}, 32'h0);
    check("rst_mem_din", mem_din, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);

    // Aligned word store/load
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    check("sw_naccs", 32'(mem_log.size()), 32'd1);
    check_acc(0, 4'b1111, 14'h0010, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

    // Byte/half extension
    set_word(14'h0020, 32'h80FF_7F01);
    do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h0000_0080, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000_007F, 1'b0, 2);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0, 2);
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000_80FF, 1'b0, 2);

    // Crossing word store and load
    set_word(14'h0030, 32'h0);
    set_word(14'h0034, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h31, 32'h1122_3344, 32'h0, 1'b0, 3);
    check("xsw_naccs", 32'(mem_log.size()), 32'd2);
    check_acc(0, 4'b0111, 14'h0031, 32'h1122_3344);
    check_acc(1, 4'b0001, 14'h0034, 32'h0000_0011);
    check("xsw_word30", get_word(14'h0030), 32'h2233_4400);
    check("xsw_word34", get_word(14'h0034), 32'h0000_0011);
    do_req(1'b0, 2'b10, 1'b0, 32'h31, 32'h0, 32'h1122_3344, 1'b0, 3);

    // Crossing half at the top of memory wraps to word 0
    mem[14'h3FFF] = 8'hAB;
    mem[14'h0000] = 8'hCD;
    do_req(1'b0, 2'b01, 1'b1, 32'h3FFF, 32'h0, 32'h0000_CDAB, 1'b0, 3);
    check_acc(1, 4'b0000, 14'h0000, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 32'h3FFF, 32'h0, 32'hFFFF_CDAB, 1'b0, 3);

    // Illegal size
    do_req(1'b1, 2'b11, 1'b0, 32'h50, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    check("illegal_naccs", 32'(mem_log.size()), 32'd0);

    // Reset during the second fragment of a split store
    set_word(14'h0040, 32'h0);
    set_word(14'h0044, 32'h0);
    drive_req(1'b1, 2'b10, 1'b0, 32'h42, 32'hAABB_CCDD);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_mem_en", {31'h0, mem_en}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("midrst_word40", get_word(14'h0040), 32'hCCDD_0000);
    check("midrst_word44", get_word(14'h0044), 32'h0);
    repeat (3) @(negedge clk);
    do_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 32'h0000_CCDD, 1'b0, 3);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
